// File: rtl/scan_capture_pkg.sv
// scan_capture_pkg: shared state encoding and digit strobe patterns for the display bus capture
package scan_capture_pkg;
  typedef enum logic {HUNT = 1'b0, TRACK = 1'b1} state_t;
  localparam logic [7:0] DIG_BLANK = 8'hFF;
  localparam logic [7:0] DIG_PAT [8] = '{
    8'b11111110, 8'b01111111, 8'b10111111, 8'b11011111,
    8'b11101111, 8'b11110111, 8'b11111011, 8'b11111101
  };
endpackage

// File: rtl/scan_decode.sv
// scan_decode: maps an active-low digit strobe pattern to {valid, blank, index}
module scan_decode
  import scan_capture_pkg::*;
(
  input  logic [7:0] i_dig,
  output logic       o_valid,
  output logic       o_blank,
  output logic [2:0] o_idx
);
  assign o_blank = i_dig == DIG_BLANK;
  always_comb begin
    o_valid = 1'b0;
    o_idx   = 3'd0;
    for (int k = 0; k < 8; k++)
      if (i_dig == DIG_PAT[k]) begin
        o_valid = 1'b1;
        o_idx   = 3'(k);
      end
  end
endmodule

// File: rtl/scan_capture.sv
// scan_capture: filters the display strobe/segment bus, checks scan order and publishes whole frames
module scan_capture
  import scan_capture_pkg::*;
#(
  parameter int HOLD    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  DIG,
  input  logic [7:0]  SEG,
  output logic [2:0]  SEL_OUT,
  output logic [63:0] FRAME_DATA,
  output logic        FRAME_VLD,
  output logic        SEQ_ERR,
  output logic        LOCKED
);
  logic [7:0]      r_dig, r_seg, r_last;
  logic [3:0]      r_stab;
  logic [15:0]     r_to;
  logic [2:0]      r_exp;
  logic [6:0][7:0] r_shadow;
  state_t          r_state, w_next;
  logic            w_valid, w_blank, w_same, w_evt, w_acc, w_bad, w_tout, w_err, w_wr, w_pub;
  logic [2:0]      w_idx;

  scan_decode u_dec (.i_dig(r_dig), .o_valid(w_valid), .o_blank(w_blank), .o_idx(w_idx));

  // r_last remembers the last pattern that became stable, so a held strobe acts once
  assign w_same = {DIG, SEG} == {r_dig, r_seg};
  assign w_evt  = (r_stab == 4'(HOLD)) && (r_dig != r_last);
  assign w_acc  = w_evt && w_valid;
  assign w_bad  = w_evt && !w_valid && !w_blank;

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_dig  <= '0;
      r_seg  <= '0;
      r_stab <= '0;
      r_last <= DIG_BLANK;
    end else begin
      r_dig  <= DIG;
      r_seg  <= SEG;
      r_stab <= w_same ? (r_stab == 4'(HOLD) ? r_stab : r_stab + 4'd1) : 4'd1;
      if (w_evt) r_last <= r_dig;
    end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) r_state <= HUNT;
    else        r_state <= w_next;

  always_comb begin
    w_tout = (r_state == TRACK) && !w_acc && (r_to == 16'(TIMEOUT - 1));
    w_err  = (r_state == TRACK) && ((w_acc && w_idx != r_exp) || w_bad || w_tout);
    w_wr   = w_acc && ((r_state == TRACK) ? w_idx == r_exp : w_idx == 3'd0);
    w_next = w_err ? HUNT : (w_wr ? TRACK : r_state);
  end

  always_comb
    w_pub = w_wr && (r_state == TRACK) && (w_idx == 3'd7) && !w_err;

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_to       <= '0;
      r_exp      <= '0;
      r_shadow   <= '0;
      SEL_OUT    <= '0;
      FRAME_DATA <= '0;
      FRAME_VLD  <= 1'b0;
      SEQ_ERR    <= 1'b0;
      LOCKED     <= 1'b0;
    end else begin
      r_to      <= (w_acc || r_state == HUNT) ? 16'd0 : r_to + 16'd1;
      FRAME_VLD <= w_pub;
      SEQ_ERR   <= w_err;
      LOCKED    <= w_next == TRACK;
      if (w_wr) begin
        r_exp   <= w_idx + 3'd1;
        SEL_OUT <= w_idx;
      end
      if (w_wr && w_idx != 3'd7) r_shadow[w_idx] <= r_seg;
      if (w_pub) FRAME_DATA <= {r_seg, r_shadow};
    end
endmodule

// File: doc/scan_capture.md
Name: scan_capture

Overview:
- Receive-side counterpart of the 8-digit display scanner; sits on the display bus and reconstructs what the scanner is driving.
- Watches the active-low walking-zero digit strobe and the shared segment bus, and stores one segment byte per digit.
- Checks that digits arrive in scan order and publishes a complete 8-digit frame once per scan cycle.
- Used for display readback, self-test and driving a mirrored display.

Parameters:
- HOLD, 2, consecutive identical CLK samples of DIG/SEG required before a strobe is accepted (glitch filter, 1..15).
- TIMEOUT, 1024, CLK cycles allowed between accepted strobes before loss of lock (2..65535).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- DIG  input  8  digit strobes {QH..QA}, active-low, exactly one low when valid.
- SEG  input  8  segment bus value for the currently strobed digit.
- SEL_OUT  output  3  index of the last accepted digit.
- FRAME_DATA  output  64  captured frame; byte k (bits 8k+7:8k) = segment byte of digit index k.
- FRAME_VLD  output  1  one-cycle pulse when FRAME_DATA updates.
- SEQ_ERR  output  1  one-cycle pulse on an ordering error, invalid pattern or timeout.
- LOCKED  output  1  high while tracking a correctly ordered scan.

Behaviour:
- Reset (async assert, sync release):
  - SEL_OUT=0, FRAME_DATA=0, FRAME_VLD=0, SEQ_ERR=0, LOCKED=0.
  - State=HUNT; shadow bank=0; counters=0.
- Index decode (fixed mapping):
  - 01111111->1, 10111111->2, 11011111->3, 11101111->4.
  - 11110111->5, 11111011->6, 11111101->7, 11111110->0.
  - Any other pattern is invalid. This includes all-ones (blank), because it has no zero.
- Glitch filter:
  - Register DIG and SEG each cycle.
  - A stability counter increments while {DIG,SEG} equals the previous sample and resets to 1 on any change.
  - A strobe is accepted once, on the cycle the counter reaches HOLD with a valid pattern.
  - No re-accept until DIG changes.
- Blank handling:
  - All-ones held stable is not an error; it is ignored.
  - Any other stable invalid pattern is an error in TRACK and ignored in HUNT.
- State machine:
  - HUNT: the first accepted index 0 writes shadow[0], sets expected=1 and moves to TRACK. Other indices are ignored.
  - TRACK, accepted index equals expected:
    - Write shadow[index].
    - SEL_OUT=index.
    - expected=expected+1 mod 8.
  - TRACK, accepted index 7:
    - Also copy the shadow bank, with the new byte 7 merged, to FRAME_DATA.
    - FRAME_VLD=1 on the cycle after acceptance.
    - expected=0.
  - TRACK, accepted index not equal to expected, or stable invalid non-blank pattern:
    - SEQ_ERR pulse; go to HUNT; shadow kept, not published.
    - If the offending index is 0, do not re-enter TRACK on this strobe. The next index 0 must be freshly accepted.
  - TRACK timeout:
    - A timeout counter resets on each accept and increments otherwise.
    - At TIMEOUT: SEQ_ERR pulse; go to HUNT.
  - LOCKED = (state==TRACK), registered.
- Latency: valid stable input -> accept after HOLD cycles; SEL_OUT, LOCKED and FRAME_VLD update 1 cycle after accept.
- FRAME_DATA holds its value between frames and is never partially updated.
- SEQ_ERR and FRAME_VLD are never high in the same cycle; an error takes precedence over publishing.
- Reset mid-frame discards the shadow bank and zeroes FRAME_DATA.

Decomposition:
- Shared package:
  - HUNT/TRACK state encoding.
  - The 8 valid DIG pattern constants.
  - Blank constant 8'hFF.
- One sub-module, scan_decode: combinational DIG -> {valid, blank, index[2:0]}, reusable by the scanner's own checker.
- Filter, FSM and frame bank stay in scan_capture.

Test Plan:
- Normal frame: reset, drive the index sequence 0..7 with SEG=8'hC0+k, each held 4 cycles (HOLD=2) -> one FRAME_VLD pulse; FRAME_DATA=64'hC7C6C5C4C3C2C1C0; LOCKED=1 from the cycle after the index 0 accept; SEQ_ERR never pulses.
- Mid-frame start: begin at index 3, continue 4..7, then 0..7 -> no publish until the second index 7; one frame only, no SEQ_ERR.
- Skipped digit: in TRACK send 0,1,3 -> SEQ_ERR pulse 1 cycle after index 3 is accepted; LOCKED=0; FRAME_DATA unchanged.
- Glitch: a 1-cycle DIG=8'b11011111 spike during a digit-1 hold -> not accepted; no error; the sequence continues.
- Timeout (TIMEOUT=16): lock, then hold DIG=8'hFF for 20 cycles -> SEQ_ERR pulse at cycle 16 after the last accept; LOCKED=0.
- Async reset: assert RST_N=0 mid-frame, off the clock edge -> all outputs 0 immediately; after release, a full 0..7 sequence is needed to get FRAME_VLD.
